// File: rtl/uart_pkg.sv
// Shared types and constants for the scheduled UART transmitter.
// The line clock and baud defaults live in parameters.h, not here.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Divides clk down to one tick per bit (times Oversampling).
// The counter reloads while disabled, so the first tick lands one full period after enable.
module baud_tick_gen #(
    parameter int ClkFrequency = 50_000_000,
    parameter int Baud         = 115_200,
    parameter int Oversampling = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int DIV   = ClkFrequency / (Baud * Oversampling);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// 8N1 UART transmitter shared by NUM_REQ byte requesters, served round-robin.
// One byte is captured and granted per frame; requests are only looked at in IDLE.
`ifndef CLK_FREQUENCY
`define CLK_FREQUENCY 50_000_000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115_200
`endif

module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ClkFrequency = `CLK_FREQUENCY,
    parameter int Baud         = `BAUD_RATE
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][DATA_BITS-1:0]   data,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                txd,
    output logic                                busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   txd_q, txd_d;
    logic                   busy_q, busy_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;

    logic                   tick_en;
    logic                   tick;
    logic [PTR_W:0]         rr_sum;
    logic [PTR_W-1:0]       sel;
    logic                   sel_valid;

    assign tick_en = (state_q != IDLE);

    baud_tick_gen #(
        .ClkFrequency (ClkFrequency),
        .Baud         (Baud),
        .Oversampling (1)
    ) u_baud_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (tick_en),
        .tick    (tick)
    );

    // Rotating priority: scan from the requester after the last grant, wrapping once.
    always_comb begin
        rr_sum    = '0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (rr_sum >= (PTR_W+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!sel_valid && req[rr_sum[PTR_W-1:0]]) begin
                sel_valid = 1'b1;
                sel       = rr_sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        grant_d   = '0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (sel_valid) begin
                    shift_d = data[sel];
                    grant_d = NUM_REQ'(1) << sel;
                    ptr_d   = sel;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Reset mid-frame simply drops everything; no frame is resumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
        end
    end

    assign grant = grant_q;
    assign txd   = txd_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: stimulus pushes expected grants and bytes,
// a negedge monitor decodes the line and checks them against the queues.
module tb_uart_tx_sched;

    localparam int NUM_REQ = 3;
    localparam int BIT_CLKS = 10;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0][7:0]   data;
    logic [NUM_REQ-1:0]        grant;
    logic                      txd;
    logic                      busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NUM_REQ-1:0] exp_grant_q[$];
    logic [7:0]         exp_byte_q[$];

    uart_tx_sched #(
        .NUM_REQ      (NUM_REQ),
        .ClkFrequency (1_000_000),
        .Baud         (100_000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .data    (data),
        .grant   (grant),
        .txd     (txd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         mon_en = 1'b0;
    logic       txd_prev = 1'b1;
    logic       busy_prev = 1'b0;
    int         idle_cnt = 0;
    int         busy_cnt = 0;
    bit         busy_valid = 1'b0;
    bit         rx_active = 1'b0;
    bit         rx_ok = 1'b1;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    logic [NUM_REQ-1:0] eg;
    logic [7:0]         eb;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_active  = 1'b0;
            busy_valid = 1'b0;
            txd_prev   = 1'b1;
            busy_prev  = 1'b0;
            idle_cnt   = 0;
        end else if (mon_en) begin
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("txd_idle_high", 32'(busy || (txd === 1'b1)), 32'd1);

            if (grant != '0) begin
                if (exp_grant_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL grant_unexpected: got %b expected none at %0t", grant, $time);
                end else begin
                    eg = exp_grant_q.pop_front();
                    check("grant", 32'(grant), 32'(eg));
                end
                check("grant_edge", {29'd0, busy, busy_prev, (idle_cnt >= 1)}, 32'b101);
            end
            if (busy) idle_cnt = 0;
            else      idle_cnt++;

            if (busy) begin
                if (!busy_prev) begin
                    busy_cnt   = 0;
                    busy_valid = 1'b1;
                end
                busy_cnt++;
            end else if (busy_prev && busy_valid) begin
                check("busy_len", 32'(busy_cnt), 32'(10 * BIT_CLKS));
                busy_valid = 1'b0;
            end

            // Line decoder: sample mid-bit, 5 clks after the falling start edge, then every bit period.
            if (!rx_active) begin
                if (txd_prev && !txd) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    rx_byte   = '0;
                    rx_ok     = 1'b1;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == 5 && txd !== 1'b0) rx_ok = 1'b0;
                if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt % 10) == 5)
                    rx_byte = {txd, rx_byte[7:1]};
                if (rx_cnt == 95) begin
                    rx_active = 1'b0;
                    if (exp_byte_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got %h expected none at %0t", rx_byte, $time);
                    end else begin
                        eb = exp_byte_q.pop_front();
                        check("frame", {22'd0, rx_ok, txd, rx_byte}, {22'd0, 1'b1, 1'b1, eb});
                    end
                end
            end
            txd_prev  = txd;
            busy_prev = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_frame(input int idx, input logic [7:0] b, input bit with_byte);
        exp_grant_q.push_back(NUM_REQ'(1) << idx);
        if (with_byte) exp_byte_q.push_back(b);
    endtask

    task automatic wait_grants(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (grant != '0) got++;
        end
        if (got < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_grant: got %0d grants expected %0d", got, n);
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((busy || rx_active || exp_grant_q.size() != 0 || exp_byte_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: got busy=%b pending=%0d expected idle",
                     busy, exp_grant_q.size() + exp_byte_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        req     = '0;
        data    = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        mon_en = 1'b1;

        // Round-robin from reset: requester 0 wins first.
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        expect_frame(0, 8'h11, 1); expect_frame(1, 8'h22, 1);
        expect_frame(2, 8'h33, 1); expect_frame(0, 8'h11, 1);
        req = 3'b111;
        wait_grants(4);
        req = 3'b000;
        wait_idle();

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1.
        data[0] = 8'hA5;
        expect_frame(0, 8'hA5, 1);
        req = 3'b001;
        wait_grants(1);
        req = 3'b000;
        wait_idle();

        // Last grant 1, then req=011 raised mid-frame: 0 wins, then 1.
        data[0] = 8'h3C; data[1] = 8'h5C;
        expect_frame(1, 8'h5C, 1); expect_frame(0, 8'h3C, 1); expect_frame(1, 8'h5C, 1);
        req = 3'b010;
        wait_grants(1);
        req = 3'b011;
        wait_grants(1);
        req = 3'b010;
        wait_grants(1);
        req = 3'b000;
        wait_idle();

        // req[2] rising mid-frame waits for the line to return idle.
        data[0] = 8'h81; data[2] = 8'hE7;
        expect_frame(0, 8'h81, 1); expect_frame(2, 8'hE7, 1);
        req = 3'b001;
        wait_grants(1);
        req = 3'b000;
        repeat (30) @(negedge clk);
        req = 3'b100;
        wait_grants(1);
        req = 3'b000;
        wait_idle();

        // Reset during DATA bit 3 aborts the frame and restores the pointer.
        data[1] = 8'h96;
        expect_frame(1, 8'h96, 0);
        req = 3'b010;
        wait_grants(1);
        req = 3'b000;
        repeat (45) @(posedge clk);
        pulse_reset();
        data[0] = 8'h4B; data[2] = 8'hD2;
        expect_frame(0, 8'h4B, 1); expect_frame(2, 8'hD2, 1);
        req = 3'b101;
        wait_grants(1);
        req = 3'b100;
        wait_grants(1);
        req = 3'b000;
        wait_idle();

        // A single requester held high is granted every frame.
        data[1] = 8'h0F;
        expect_frame(1, 8'h0F, 1); expect_frame(1, 8'h0F, 1); expect_frame(1, 8'h0F, 1);
        req = 3'b010;
        wait_grants(3);
        req = 3'b000;
        wait_idle();

        check("queues_empty", 32'(exp_grant_q.size() + exp_byte_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
